// File: rtl/kyber_pkg.sv
// Kyber constants shared by the twiddle sequencer: modulus, widths, mode and state types,
// plus the small arithmetic helpers used when forming output beats.
package kyber_pkg;

    localparam int KYBER_W         = 12;
    localparam int KYBER_Q         = 3329;
    localparam int KYBER_N         = 256;
    localparam int KYBER_INV_SCALE = 3303;

    typedef enum logic [1:0] {
        MODE_FWD     = 2'd0,
        MODE_INV     = 2'd1,
        MODE_BASEMUL = 2'd2
    } mode_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2
    } state_e;

    // Zero stays zero so the result is always a canonical residue in [0, q-1].
    function automatic logic [KYBER_W-1:0] mod_neg(input logic [KYBER_W-1:0] z,
                                                   input logic [KYBER_W-1:0] q);
        return (z == '0) ? '0 : q - z;
    endfunction

    function automatic logic [2:0] floor_log2(input logic [6:0] k);
        logic [2:0] l;
        l = '0;
        for (int i = 0; i < 7; i++)
            if (k[i]) l = 3'(i);
        return l;
    endfunction

endpackage

// File: rtl/zeta_rom.sv
// 128-entry Kyber zeta table, zetas[k] = 17^brv7(k) mod 3329, with a registered read port.
module zeta_rom
    import kyber_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic [6:0]         addr,
    output logic [KYBER_W-1:0] data
);

    localparam logic [KYBER_W-1:0] ZETAS [128] = '{
        12'd1,    12'd1729, 12'd2580, 12'd3289, 12'd2642, 12'd630,  12'd1897, 12'd848,
        12'd1062, 12'd1919, 12'd193,  12'd797,  12'd2786, 12'd3260, 12'd569,  12'd1746,
        12'd296,  12'd2447, 12'd1339, 12'd1476, 12'd3046, 12'd56,   12'd2240, 12'd1333,
        12'd1426, 12'd2094, 12'd535,  12'd2882, 12'd2393, 12'd2879, 12'd1974, 12'd821,
        12'd289,  12'd331,  12'd3253, 12'd1756, 12'd1197, 12'd2304, 12'd2277, 12'd2055,
        12'd650,  12'd1977, 12'd2513, 12'd632,  12'd2865, 12'd33,   12'd1320, 12'd1915,
        12'd2319, 12'd1435, 12'd807,  12'd452,  12'd1438, 12'd2868, 12'd1534, 12'd2402,
        12'd2647, 12'd2617, 12'd1481, 12'd648,  12'd2474, 12'd3110, 12'd1227, 12'd910,
        12'd17,   12'd2761, 12'd583,  12'd2649, 12'd1637, 12'd723,  12'd2288, 12'd1100,
        12'd1409, 12'd2662, 12'd3281, 12'd233,  12'd756,  12'd2156, 12'd3015, 12'd3050,
        12'd1703, 12'd1651, 12'd2789, 12'd1789, 12'd1847, 12'd952,  12'd1461, 12'd2687,
        12'd939,  12'd2308, 12'd2437, 12'd2388, 12'd733,  12'd2337, 12'd268,  12'd641,
        12'd1584, 12'd2298, 12'd2037, 12'd3220, 12'd375,  12'd2549, 12'd2090, 12'd1645,
        12'd1063, 12'd319,  12'd2773, 12'd757,  12'd2099, 12'd561,  12'd2466, 12'd2594,
        12'd2804, 12'd1092, 12'd403,  12'd1026, 12'd1143, 12'd2150, 12'd2775, 12'd886,
        12'd1722, 12'd1212, 12'd1874, 12'd1029, 12'd2110, 12'd2935, 12'd885,  12'd2154
    };

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)  data <= '0;
        else if (en) data <= ZETAS[addr];
    end

endmodule

// File: rtl/twiddle_sequencer.sv
// Streams the twiddle factors for one forward NTT, inverse NTT or basemul pass, in issue order.
// Pipeline: index counter -> registered table read (stage 1) -> output register (stage 2).
//   state   | meaning
//   S_IDLE  | waiting for start; first fetch is issued in the accepting cycle
//   S_RUN   | issuing table indices, one per cycle while downstream has room
//   S_FLUSH | all indices issued; draining until the last beat handshakes
module twiddle_sequencer
    import kyber_pkg::*;
#(
    parameter int W         = KYBER_W,
    parameter int Q         = KYBER_Q,
    parameter int LOGN      = 7,
    parameter int INV_SCALE = KYBER_INV_SCALE
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [1:0]      mode,
    output logic            busy,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [2*W-1:0]  out_data,
    output logic [2:0]      out_layer,
    output logic [LOGN-1:0] out_group,
    output logic            out_last,
    output logic            done
);

    state_e          state, state_nxt;
    mode_e           mode_q, cur_mode, s1_mode;
    logic [LOGN-1:0] idx, cur_idx, cur_group, s1_group;
    logic [2:0]      cur_layer, s1_layer;
    logic            scale_q, cur_scale, cur_last;
    logic            s1_valid, s1_last, s1_scale;
    logic            accept, issue, s1_free, s2_load;
    logic [W-1:0]    rom_q;

    // Current item: taken from the mode input in the accepting cycle, else from the counter.
    always_comb begin
        cur_mode  = mode_q;
        cur_idx   = idx;
        cur_scale = scale_q;
        if (state == S_IDLE) begin
            cur_mode  = mode_e'(mode);
            cur_scale = 1'b0;
            case (cur_mode)
                MODE_INV:     cur_idx = '1;
                MODE_BASEMUL: cur_idx = LOGN'(1) << (LOGN - 1);
                default:      cur_idx = LOGN'(1);
            endcase
        end
        cur_last  = (cur_mode == MODE_INV) ? cur_scale : (&cur_idx);
        cur_layer = floor_log2(cur_idx);
        cur_group = cur_idx & ~(LOGN'(1) << cur_layer);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (accept) state_nxt = S_RUN;
            S_RUN:   if (issue && cur_last) state_nxt = S_FLUSH;
            S_FLUSH: if (out_valid && out_ready && out_last) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        busy    = (state != S_IDLE);
        accept  = (state == S_IDLE) && start && (mode != 2'd3);
        s2_load = !out_valid || out_ready;
        s1_free = !s1_valid || s2_load;
        issue   = s1_free && (accept || (state == S_RUN));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q  <= MODE_FWD;
            idx     <= '0;
            scale_q <= 1'b0;
        end else if (issue) begin
            mode_q  <= cur_mode;
            idx     <= (cur_mode == MODE_INV) ? cur_idx - LOGN'(1) : cur_idx + LOGN'(1);
            scale_q <= (cur_mode == MODE_INV) && (cur_idx == LOGN'(1));
        end
    end

    zeta_rom u_rom (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (issue && !cur_scale),
        .addr (cur_idx),
        .data (rom_q)
    );

    // Stage 1 metadata travels alongside the registered table word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_last  <= 1'b0;
            s1_scale <= 1'b0;
            s1_mode  <= MODE_FWD;
            s1_layer <= '0;
            s1_group <= '0;
        end else if (issue) begin
            s1_valid <= 1'b1;
            s1_last  <= cur_last;
            s1_scale <= cur_scale;
            s1_mode  <= cur_mode;
            s1_layer <= cur_scale ? 3'd7 : cur_layer;
            s1_group <= cur_scale ? '0 : cur_group;
        end else if (s1_free) begin
            s1_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
            out_layer <= '0;
            out_group <= '0;
            done      <= 1'b0;
        end else begin
            done <= out_valid && out_ready && out_last;
            if (s2_load) begin
                out_valid <= s1_valid;
                out_last  <= s1_valid && s1_last;
                if (s1_valid) begin
                    out_layer <= s1_layer;
                    out_group <= s1_group;
                    case (s1_mode)
                        MODE_INV:     out_data <= {{W{1'b0}},
                                                   s1_scale ? W'(INV_SCALE) : mod_neg(rom_q, W'(Q))};
                        MODE_BASEMUL: out_data <= {mod_neg(rom_q, W'(Q)), rom_q};
                        default:      out_data <= {{W{1'b0}}, rom_q};
                    endcase
                end
            end
        end
    end

endmodule

// File: doc/twiddle_sequencer.md
Name: twiddle_sequencer

Overview:
- Parametrised successor to the fixed 128-entry Kyber zeta table.
- Holds the zeta table internally (zetas[k] = 17^brv7(k) mod Q) and streams the twiddles needed by the NTT datapath for a whole transform, in issue order.
- Supports three modes: forward NTT, inverse NTT (negated and reversed, plus a final scale constant), and basemul gamma pairs.
- Sits between the NTT controller (start/mode) and the butterfly/basemul unit (valid/ready stream).

Parameters:
- W, 12, coefficient width.
- Q, 3329, modulus; all emitted values are in [0, Q-1].
- LOGN, 7, log2 of table depth (128 entries).
- INV_SCALE, 3303, 128^-1 mod Q, emitted as the final INV beat.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request; sampled only when busy=0.
- mode  in  2  sampled with start: 0=FWD, 1=INV, 2=BASEMUL, 3=reserved.
- busy  out  1  high from the cycle after an accepted start until the cycle after the last beat handshake.
- out_valid  out  1  beat available.
- out_ready  in  1  consumer accepts the beat when out_valid&out_ready.
- out_data  out  2*W  packed {hi, lo}.
- out_layer  out  3  layer tag.
- out_group  out  LOGN  group index within the layer.
- out_last  out  1  marks the final beat of the transform.
- done  out  1  one-cycle pulse in the cycle after the last handshake.

Behaviour:
- Reset: busy, out_valid, out_last and done are 0; out_data, out_layer and out_group are 0. All state returns to IDLE.
- States:
  - IDLE -> RUN on start with mode != 3. Mode 3 is ignored: stays IDLE, no busy.
  - RUN -> FLUSH when the final index has been fetched.
  - FLUSH -> IDLE on the last handshake.
- start while busy is ignored.
- Table read is registered. First out_valid is asserted 2 cycles after start (fetch cycle, then output register).
- A skid/prefetch stage sustains 1 beat per clock while out_ready=1, with no bubbles.
- While out_valid=1 and out_ready=0, all out_* signals hold stable. out_valid never drops without a handshake.
- FWD mode:
  - k = 1..127, 127 beats.
  - out_data = {0, zetas[k]}.
  - out_layer = floor(log2 k); out_group = k - 2^layer.
- INV mode:
  - k = 127 down to 1: out_data = {0, Q - zetas[k]}, layer/group as in FWD.
  - Then a 128th beat: out_data = {0, INV_SCALE}, layer = 7, group = 0.
- BASEMUL mode:
  - i = 0..63, 64 beats.
  - z = zetas[64+i]; out_data = {Q - z, z}; layer = 6; group = i.
- Negation: Q - z is computed as a W-bit subtract. z = 0 would map to 0, but no table entry is 0. The bench still checks the guard.
- out_last is high only on the final beat of each mode. done pulses exactly once per transform.
- Reset asserted mid-transform aborts immediately. After release, the next start restarts from the first beat.
- start is accepted in the cycle done pulses (busy already 0): back-to-back transforms are allowed.

Decomposition:
- Shared package kyber_pkg:
  - Q, W, N=256, INV_SCALE.
  - mode enum {MODE_FWD, MODE_INV, MODE_BASEMUL}.
  - Function for modular negate.
- One sub-module: zeta_rom, a 128 x W synchronous-read table with a single address port.
- Index counter, FSM, negate and skid buffer live in the top level.

Test Plan:
- FWD, out_ready tied 1:
  - start at cycle t -> out_valid at t+2.
  - Beat 0 = 0x6c1 (layer 0, group 0); beat 1 = 0xa14 (layer 1, group 0).
  - Beat 126 = 0x86a (layer 6, group 63) with out_last.
  - done at the next cycle; 127 beats with no gaps.
- INV:
  - Beat 0 = 3329 - 0x86a = 1175 (layer 6, group 63).
  - Beat 126 = 3329 - 1729 = 1600 (layer 0).
  - Beat 127 = 3303 (layer 7) with out_last.
- BASEMUL:
  - Beat 0 = {3312, 17}.
  - Beat 63 = {1175, 2154} with out_last; exactly 64 beats.
- Backpressure: random out_ready (50%) in FWD mode.
  - out_* are stable while stalled.
  - The sequence is identical to the ready=1 run; no loss or duplication.
- start pulses during busy and with mode=3 -> ignored; the transform in flight is unaffected, and a mode=3 start in IDLE leaves busy=0.
- rst_n low at beat 40 of FWD -> all outputs 0 asynchronously.
  - A new FWD start after release emits 0x6c1 first.
